// File: rtl/vote_channel_arbiter.sv
// Round-robin arbiter sharing one rts/cts voter channel among N_REQ requesters.
// Optional handshake abort is compiled in with `define VCA_TIMEOUT_EN.
module vote_channel_arbiter #(
   parameter int N_REQ   = 4,
   parameter int DW      = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   input  logic                cts,
   output logic                rts,
   output logic [DW-1:0]       v_out,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    ack,
   output logic                busy,
   output logic                err
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEND    = 3'd1,
      S_RELEASE = 3'd2,
      S_DONE    = 3'd3,
      S_ABORT   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [PW-1:0]      win_q, win_d;
   logic               rts_q, rts_d;
   logic [DW-1:0]      v_out_q, v_out_d;
   logic [N_REQ-1:0]   gnt_q, gnt_d;
   logic [N_REQ-1:0]   ack_q, ack_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;
   logic               found_s;
   logic [PW-1:0]      win_s;
   logic [PW-1:0]      ptr_inc_s;
   int                 idx_s;
`ifdef VCA_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               tmo_s;
   assign tmo_s = (cnt_q == CW'(TIMEOUT - 1));
`endif

   // Rotating search: first active request at or after ptr, wrapping by explicit compare.
   always_comb begin
      found_s = 1'b0;
      win_s   = '0;
      idx_s   = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx_s = int'(ptr_q) + k;
         if (idx_s >= N_REQ) idx_s = idx_s - N_REQ;
         else                idx_s = idx_s;
         if (!found_s && req[idx_s]) begin
            found_s = 1'b1;
            win_s   = PW'(idx_s);
         end else begin
            found_s = found_s;
         end
      end
      if (win_q == PW'(N_REQ - 1)) ptr_inc_s = '0;
      else                         ptr_inc_s = win_q + PW'(1);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         rts_q   <= 1'b0;
         v_out_q <= '0;
         gnt_q   <= '0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef VCA_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         win_q   <= win_d;
         rts_q   <= rts_d;
         v_out_q <= v_out_d;
         gnt_q   <= gnt_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
`ifdef VCA_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Next state; a timeout takes priority over a cts arriving in the same cycle.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (found_s && !cts) state_d = S_SEND;
            else                 state_d = S_IDLE;
         end
         S_SEND: begin
`ifdef VCA_TIMEOUT_EN
            if (tmo_s)     state_d = S_ABORT;
            else if (cts)  state_d = S_RELEASE;
            else           state_d = S_SEND;
`else
            if (cts)       state_d = S_RELEASE;
            else           state_d = S_SEND;
`endif
         end
         S_RELEASE: begin
`ifdef VCA_TIMEOUT_EN
            if (tmo_s)     state_d = S_ABORT;
            else if (!cts) state_d = S_DONE;
            else           state_d = S_RELEASE;
`else
            if (!cts)      state_d = S_DONE;
            else           state_d = S_RELEASE;
`endif
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered-output next values, derived from the current and next state.
   always_comb begin
      ptr_d   = ptr_q;
      win_d   = win_q;
      rts_d   = rts_q;
      v_out_d = v_out_q;
      gnt_d   = gnt_q;
      ack_d   = '0;
      err_d   = 1'b0;
      busy_d  = (state_d != S_IDLE);
`ifdef VCA_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (state_d == S_SEND) begin
               rts_d   = 1'b1;
               win_d   = win_s;
               v_out_d = req_data[win_s*DW +: DW];
               gnt_d   = N_REQ'(1) << win_s;
`ifdef VCA_TIMEOUT_EN
               cnt_d   = '0;
`endif
            end else begin
               rts_d   = 1'b0;
            end
         end
         S_SEND, S_RELEASE: begin
`ifdef VCA_TIMEOUT_EN
            cnt_d = cnt_q + CW'(1);
            if (state_d == S_ABORT) begin
               rts_d = 1'b0;
               err_d = 1'b1;
               ack_d = N_REQ'(1) << win_q;
            end else begin
               err_d = 1'b0;
            end
`endif
            if (state_d == S_RELEASE)   rts_d = 1'b0;
            else if (state_d == S_DONE) ack_d = N_REQ'(1) << win_q;
            else                        rts_d = rts_d;
         end
         S_DONE, S_ABORT: begin
            gnt_d = '0;
            rts_d = 1'b0;
            ptr_d = ptr_inc_s;
         end
         default: begin
            gnt_d = '0;
            rts_d = 1'b0;
         end
      endcase
   end

   assign rts   = rts_q;
   assign v_out = v_out_q;
   assign gnt   = gnt_q;
   assign ack   = ack_q;
   assign busy  = busy_q;
   assign err   = err_q;

endmodule

// File: tb/tb_vote_channel_arbiter.sv
// Directed bench for vote_channel_arbiter: cycle-accurate vector table plus
// hand sequences for round-robin rotation, mid-handshake reset and timeout.
module tb_vote_channel_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [15:0] req_data;
   logic        cts;
   logic        rts;
   logic [3:0]  v_out;
   logic [3:0]  gnt;
   logic [3:0]  ack;
   logic        busy;
   logic        err;

   int n_chk  = 0;
   int n_fail = 0;

   vote_channel_arbiter #(.N_REQ(4), .DW(4), .TIMEOUT(15)) dut (
      .clock    (clock),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .cts      (cts),
      .rts      (rts),
      .v_out    (v_out),
      .gnt      (gnt),
      .ack      (ack),
      .busy     (busy),
      .err      (err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        rst_n;
      logic [3:0]  req;
      logic [15:0] data;
      logic        cts;
      logic        e_rts;
      logic [3:0]  e_gnt;
      logic [3:0]  e_ack;
      logic        e_busy;
      logic [3:0]  e_v;
      logic        e_err;
   } vec_t;

   vec_t vecs [25];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0; req = 4'b0000; req_data = 16'h0000; cts = 1'b0;

      //          rst  req     data      cts   rts   gnt     ack     busy  v      err
      vecs[0]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[1]  = '{1'b1, 4'h1, 16'h000A, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 4'hA, 1'b0};
      vecs[2]  = '{1'b1, 4'h0, 16'h000A, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 4'hA, 1'b0};
      vecs[3]  = '{1'b1, 4'h0, 16'h000A, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 4'hA, 1'b0};
      vecs[4]  = '{1'b1, 4'h0, 16'h000A, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 4'hA, 1'b0};
      vecs[5]  = '{1'b1, 4'h0, 16'h000A, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'hA, 1'b0};
      vecs[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[7]  = '{1'b1, 4'h5, 16'h0301, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0};
      vecs[8]  = '{1'b1, 4'h5, 16'h0F0E, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0};
      vecs[9]  = '{1'b1, 4'h5, 16'h0301, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 4'h1, 1'b0};
      vecs[10] = '{1'b1, 4'h5, 16'h0301, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h1, 1'b0};
      vecs[11] = '{1'b1, 4'h5, 16'h0301, 1'b0, 1'b1, 4'h4, 4'h0, 1'b1, 4'h3, 1'b0};
      vecs[12] = '{1'b1, 4'h5, 16'h0301, 1'b1, 1'b0, 4'h4, 4'h0, 1'b1, 4'h3, 1'b0};
      vecs[13] = '{1'b1, 4'h0, 16'h0301, 1'b0, 1'b0, 4'h4, 4'h4, 1'b1, 4'h3, 1'b0};
      vecs[14] = '{1'b1, 4'h0, 16'h0301, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h3, 1'b0};
      vecs[15] = '{1'b1, 4'h9, 16'h5301, 1'b0, 1'b1, 4'h8, 4'h0, 1'b1, 4'h5, 1'b0};
      vecs[16] = '{1'b1, 4'h0, 16'h5301, 1'b1, 1'b0, 4'h8, 4'h0, 1'b1, 4'h5, 1'b0};
      vecs[17] = '{1'b1, 4'h0, 16'h5301, 1'b0, 1'b0, 4'h8, 4'h8, 1'b1, 4'h5, 1'b0};
      vecs[18] = '{1'b1, 4'h0, 16'h5301, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h5, 1'b0};
      vecs[19] = '{1'b1, 4'h1, 16'h5301, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h5, 1'b0};
      vecs[20] = '{1'b1, 4'h1, 16'h5301, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h5, 1'b0};
      vecs[21] = '{1'b1, 4'h1, 16'h5301, 1'b0, 1'b1, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0};
      vecs[22] = '{1'b1, 4'h0, 16'h5301, 1'b1, 1'b0, 4'h1, 4'h0, 1'b1, 4'h1, 1'b0};
      vecs[23] = '{1'b1, 4'h0, 16'h5301, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 4'h1, 1'b0};
      vecs[24] = '{1'b1, 4'h0, 16'h5301, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h1, 1'b0};

      // Single request, two-requester rotation, pointer carry-over, stale cts in IDLE.
      for (int i = 0; i < 25; i++) begin
         reset    = vecs[i].rst_n;
         req      = vecs[i].req;
         req_data = vecs[i].data;
         cts      = vecs[i].cts;
         tick();
         check($sformatf("v%0d.rts", i),  {31'd0, rts},  {31'd0, vecs[i].e_rts});
         check($sformatf("v%0d.gnt", i),  {28'd0, gnt},  {28'd0, vecs[i].e_gnt});
         check($sformatf("v%0d.ack", i),  {28'd0, ack},  {28'd0, vecs[i].e_ack});
         check($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
         check($sformatf("v%0d.vout", i), {28'd0, v_out}, {28'd0, vecs[i].e_v});
         check($sformatf("v%0d.err", i),  {31'd0, err},  {31'd0, vecs[i].e_err});
      end

      // All four requesting with a responsive voter: order 0,1,2,3,0.
      reset = 1'b0; req = 4'b0000; cts = 1'b0; req_data = 16'h4321;
      tick();
      reset = 1'b1; req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         logic [3:0] oh;
         oh = 4'b0001 << (t % 4);
         tick();
         check($sformatf("rr%0d.rts", t), {31'd0, rts}, 32'd1);
         check($sformatf("rr%0d.gnt", t), {28'd0, gnt}, {28'd0, oh});
         check($sformatf("rr%0d.vout", t), {28'd0, v_out}, {28'd0, 4'((t % 4) + 1)});
         cts = 1'b1;
         tick();
         check($sformatf("rr%0d.rts_low", t), {31'd0, rts}, 32'd0);
         cts = 1'b0;
         tick();
         check($sformatf("rr%0d.ack", t), {28'd0, ack}, {28'd0, oh});
         tick();
         check($sformatf("rr%0d.ack_clr", t), {28'd0, ack}, 32'd0);
         check($sformatf("rr%0d.idle", t), {31'd0, busy}, 32'd0);
      end

      // Reset in SEND drops everything at that edge; pointer returns to 0.
      req = 4'b0001;
      tick();
      check("rst.pre_rts", {31'd0, rts}, 32'd1);
      reset = 1'b0;
      tick();
      check("rst.rts",  {31'd0, rts},  32'd0);
      check("rst.gnt",  {28'd0, gnt},  32'd0);
      check("rst.busy", {31'd0, busy}, 32'd0);
      reset = 1'b1; req = 4'b0011;
      tick();
      check("rst.ptr0_gnt", {28'd0, gnt}, 32'd1);
      req = 4'b0000; cts = 1'b1;
      tick();
      cts = 1'b0;
      tick();
      tick();
      check("rst.done_idle", {31'd0, busy}, 32'd0);

      // Voter never answers.
      reset = 1'b0;
      tick();
      reset = 1'b1; req = 4'b0001; cts = 1'b0;
      tick();
      check("tmo.rts_rise", {31'd0, rts}, 32'd1);
      req = 4'b0000;
`ifdef VCA_TIMEOUT_EN
      for (int c = 0; c < 14; c++) begin
         tick();
         check($sformatf("tmo.hold%0d", c), {31'd0, rts}, 32'd1);
         check($sformatf("tmo.noerr%0d", c), {31'd0, err}, 32'd0);
      end
      tick();
      check("tmo.err", {31'd0, err}, 32'd1);
      check("tmo.ack", {28'd0, ack}, 32'd1);
      check("tmo.rts", {31'd0, rts}, 32'd0);
      tick();
      check("tmo.err_clr", {31'd0, err}, 32'd0);
      check("tmo.ack_clr", {28'd0, ack}, 32'd0);
      check("tmo.idle",    {31'd0, busy}, 32'd0);
`else
      for (int c = 0; c < 40; c++) begin
         tick();
         check($sformatf("wait.rts%0d", c), {31'd0, rts}, 32'd1);
         check($sformatf("wait.err%0d", c), {31'd0, err}, 32'd0);
         check($sformatf("wait.gnt%0d", c), {28'd0, gnt}, 32'd1);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
